// File: rtl/audio_pkg.sv
// audio_pkg: shared FSM state, stereo sample type and default widths for the I2S scheduler
package audio_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int SLOT_W_DEF = 17;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] left;
        logic [DATA_W_DEF-1:0] right;
    } stereo_t;

endpackage

// File: rtl/i2s_frame_scheduler_if.sv
// i2s_frame_scheduler_if: source handshakes, control and codec-side outputs of the scheduler
interface i2s_frame_scheduler_if #(
    parameter int DATA_W = audio_pkg::DATA_W_DEF
);

    logic              enable;
    logic              src_sel;
    logic              s0_valid;
    logic              s1_valid;
    logic [DATA_W-1:0] s0_left;
    logic [DATA_W-1:0] s0_right;
    logic [DATA_W-1:0] s1_left;
    logic [DATA_W-1:0] s1_right;
    logic              s0_ready;
    logic              s1_ready;
    logic              word_select;
    logic              sound_bit_out;
    logic              frame_start;
    logic              underrun;
    logic              active_src;

    modport master (
        output enable, src_sel, s0_valid, s1_valid, s0_left, s0_right, s1_left, s1_right,
        input  s0_ready, s1_ready, word_select, sound_bit_out, frame_start, underrun, active_src
    );

    modport slave (
        input  enable, src_sel, s0_valid, s1_valid, s0_left, s0_right, s1_left, s1_right,
        output s0_ready, s1_ready, word_select, sound_bit_out, frame_start, underrun, active_src
    );

endinterface

// File: rtl/i2s_serializer.sv
// i2s_serializer: frame register and position-to-pin mapping, registered from next-state
module i2s_serializer
    import audio_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SLOT_W = SLOT_W_DEF,
    parameter int PW     = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          run_i,
    input  logic [PW-1:0] p_i,
    input  stereo_t       pair_i,
    output logic          word_select_o,
    output logic          sound_bit_o
);

    localparam int IW = $clog2(DATA_W);

    stereo_t       frame_q, frame_d;
    logic          ws_q, ws_d, bit_q, bit_d;
    logic [IW-1:0] li, ri;
    int            pos;

    // pick the bit for the position the next cycle will hold, from the frame it will hold
    always_comb begin
        frame_d = load_i ? pair_i : frame_q;
        pos     = int'(p_i);
        li      = IW'(DATA_W - 1 - pos);
        ri      = IW'(SLOT_W + DATA_W - 1 - pos);
        ws_d    = run_i && (pos >= SLOT_W);
        bit_d   = !run_i                                 ? 1'b0 :
                  (pos < DATA_W)                         ? frame_d.left[li] :
                  (pos >= SLOT_W && pos < SLOT_W+DATA_W) ? frame_d.right[ri] : 1'b0;
    end

    // frame register and output pins
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            ws_q    <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            frame_q <= frame_d;
            ws_q    <= ws_d;
            bit_q   <= bit_d;
        end
    end

    assign word_select_o = ws_q;
    assign sound_bit_o   = bit_q;

endmodule

// File: rtl/i2s_frame_scheduler.sv
// i2s_frame_scheduler: frame sequencing, two-source arbitration and holding register for I2S TX
module i2s_frame_scheduler
    import audio_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SLOT_W = SLOT_W_DEF
) (
    input  logic                    serial_clk,
    input  logic                    reset,
    i2s_frame_scheduler_if.slave    bus
);

    localparam int            FRAME = 2 * SLOT_W;
    localparam int            PW    = $clog2(FRAME);
    localparam logic [PW-1:0] LAST  = PW'(FRAME - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic          hold_full_q, hold_full_d;
    stereo_t       hold_q, hold_d, next_pair;
    logic          active_src_q, active_src_d;
    logic          frame_start_q, underrun_q;
    logic          last, load, grant, acc0, acc1;

    // state and position register
    always_ff @(posedge serial_clk) begin
        if (reset) begin
            state_q <= IDLE;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
        end
    end

    // next state: enable is only looked at in IDLE or on the last position, so frames always complete
    always_comb begin
        last    = (state_q == RUN) && (p_q == LAST);
        load    = bus.enable && ((state_q == IDLE) || last);
        state_d = (state_q == IDLE) ? (bus.enable ? RUN : IDLE) : ((last && !bus.enable) ? IDLE : RUN);
        p_d     = (state_d == RUN && !load) ? p_q + 1'b1 : '0;
    end

    // arbitration: the new grant applies from the load cycle itself, so a switch never admits the old source again
    always_comb begin
        grant        = load ? bus.src_sel : active_src_q;
        bus.s0_ready = !reset && !grant && (!hold_full_q || load);
        bus.s1_ready = !reset &&  grant && (!hold_full_q || load);
        acc0         = bus.s0_valid && bus.s0_ready;
        acc1         = bus.s1_valid && bus.s1_ready;
        hold_full_d  = acc0 || acc1 || (hold_full_q && !load);
        hold_d       = acc1 ? '{left: bus.s1_left, right: bus.s1_right} :
                       acc0 ? '{left: bus.s0_left, right: bus.s0_right} : hold_q;
        active_src_d = grant;
        next_pair    = hold_full_q ? hold_q : '0;
    end

    // holding register, grant and frame-boundary pulses
    always_ff @(posedge serial_clk) begin
        if (reset) begin
            hold_full_q   <= 1'b0;
            hold_q        <= '0;
            active_src_q  <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            hold_full_q   <= hold_full_d;
            hold_q        <= hold_d;
            active_src_q  <= active_src_d;
            frame_start_q <= load;
            underrun_q    <= load && !hold_full_q;
        end
    end

    i2s_serializer #(
        .DATA_W (DATA_W),
        .SLOT_W (SLOT_W),
        .PW     (PW)
    ) u_ser (
        .clk           (serial_clk),
        .rst           (reset),
        .load_i        (load),
        .run_i         (state_d == RUN),
        .p_i           (p_d),
        .pair_i        (next_pair),
        .word_select_o (bus.word_select),
        .sound_bit_o   (bus.sound_bit_out)
    );

    assign bus.frame_start = frame_start_q;
    assign bus.underrun    = underrun_q;
    assign bus.active_src  = active_src_q;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// tb_i2s_frame_scheduler: scoreboard bench for the I2S frame scheduler
module tb_i2s_frame_scheduler;
    import audio_pkg::*;

    localparam int DW = 16;
    localparam int SW = 17;
    localparam int FL = 2 * SW;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic          ur;
        logic          src;
    } exp_t;

    logic serial_clk = 1'b0;
    logic reset      = 1'b1;

    i2s_frame_scheduler_if #(.DATA_W(DW)) bus ();

    i2s_frame_scheduler #(.DATA_W(DW), .SLOT_W(SW)) dut (
        .serial_clk (serial_clk),
        .reset      (reset),
        .bus        (bus.slave)
    );

    always #5 serial_clk = ~serial_clk;

    exp_t          sb[$];
    exp_t          cur;
    int            n_tests = 0;
    int            n_fail  = 0;
    bit            m_run, m_full, m_src;
    int            m_p;
    logic [DW-1:0] m_l, m_r;
    bit            load, grant, r0, r1;
    int            cap_pos = -1;
    logic [FL-1:0] bits, wss;
    int            frames = 0;
    int            s1x = 0;
    int            ur_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // monitor and reference model, evaluated between edges
    always @(negedge serial_clk) begin
        if (reset) begin
            m_run = 0; m_p = 0; m_full = 0; m_src = 0; m_l = '0; m_r = '0;
            sb.delete();
            cap_pos = -1;
        end else begin
            if (bus.underrun) ur_cnt++;
            if (bus.s1_valid && bus.s1_ready) s1x++;
            if (bus.frame_start) begin
                if (cap_pos >= 0) chk("frame_len", 64'(cap_pos), 64'(FL));
                if (sb.size() == 0) begin
                    chk("frame_start_unexpected", bus.frame_start, 0);
                    cap_pos = -1;
                end else begin
                    cur = sb.pop_front();
                    chk("underrun", bus.underrun, cur.ur);
                    chk("active_src", bus.active_src, cur.src);
                    cap_pos = 0;
                end
            end else if (bus.underrun) begin
                chk("underrun_stray", bus.underrun, 0);
            end
            if (cap_pos >= 0) begin
                bits[FL-1-cap_pos] = bus.sound_bit_out;
                wss[FL-1-cap_pos]  = bus.word_select;
                cap_pos++;
                if (cap_pos == FL) begin
                    chk("left", bits[33:18], cur.l);
                    chk("pad_left", bits[17], 0);
                    chk("right", bits[16:1], cur.r);
                    chk("pad_right", bits[0], 0);
                    chk("word_select", wss, {17'h0, 17'h1FFFF});
                    frames++;
                    cap_pos = -1;
                end
            end
            load  = bus.enable && (!m_run || m_p == FL - 1);
            grant = load ? bus.src_sel : m_src;
            r0    = !grant && (!m_full || load);
            r1    =  grant && (!m_full || load);
            chk("s0_ready", bus.s0_ready, r0);
            chk("s1_ready", bus.s1_ready, r1);
            if (load) begin
                sb.push_back(m_full ? exp_t'{l: m_l, r: m_r, ur: 1'b0, src: grant}
                                    : exp_t'{l: '0, r: '0, ur: 1'b1, src: grant});
                m_full = 0;
                m_src  = grant;
            end
            if (r0 && bus.s0_valid) begin m_l = bus.s0_left; m_r = bus.s0_right; m_full = 1; end
            if (r1 && bus.s1_valid) begin m_l = bus.s1_left; m_r = bus.s1_right; m_full = 1; end
            if (load) begin
                m_run = 1; m_p = 0;
            end else if (m_run) begin
                if (m_p == FL - 1) begin m_run = 0; m_p = 0; end
                else m_p++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge serial_clk);
        #1;
    endtask

    task automatic wait_p(input int t);
        int k = 0;
        while (!(m_run && m_p == t) && k < 200) begin step(1); k++; end
        chk("wait_position", k < 200, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (m_run && k < 200) begin step(1); k++; end
        chk("wait_idle", k < 200, 1);
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (frames < n && k < 200) begin step(1); k++; end
        chk("wait_frames", k < 200, 1);
    endtask

    task automatic chk_idle(input string t);
        chk({t, "_ws"}, bus.word_select, 0);
        chk({t, "_bit"}, bus.sound_bit_out, 0);
        chk({t, "_fs"}, bus.frame_start, 0);
        chk({t, "_ur"}, bus.underrun, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, s, u;
        bus.enable = 0; bus.src_sel = 0; bus.s0_valid = 0; bus.s1_valid = 0;
        bus.s0_left = '0; bus.s0_right = '0; bus.s1_left = '0; bus.s1_right = '0;
        repeat (4) begin
            bus.enable   = 1'($urandom_range(0, 1));
            bus.src_sel  = 1'($urandom_range(0, 1));
            bus.s0_valid = 1'($urandom_range(0, 1));
            bus.s1_valid = 1'($urandom_range(0, 1));
            bus.s0_left  = 16'($urandom);
            bus.s1_right = 16'($urandom);
            step(1);
        end
        chk_idle("reset");
        chk("reset_s0_ready", bus.s0_ready, 0);
        chk("reset_s1_ready", bus.s1_ready, 0);
        chk("reset_active_src", bus.active_src, 0);
        bus.enable = 0; bus.src_sel = 0; bus.s0_valid = 0; bus.s1_valid = 0;
        reset = 0;
        step(3);
        chk_idle("idle");

        f = frames;
        bus.s0_left = 16'hA5F0; bus.s0_right = 16'h0F3C; bus.s0_valid = 1;
        step(1);
        bus.s0_valid = 0; bus.enable = 1;
        step(1);
        bus.enable = 0;
        wait_idle();
        step(2);
        chk("single_frames", 64'(frames - f), 1);
        chk_idle("single_after");

        f = frames; u = ur_cnt;
        bus.enable = 1;
        wait_p(3);
        bus.s0_left = 16'h8000; bus.s0_right = 16'h0001; bus.s0_valid = 1;
        step(1);
        bus.s0_valid = 0;
        wait_frames(f + 1);
        bus.enable = 0;
        wait_idle();
        step(2);
        chk("underrun_frames", 64'(frames - f), 2);
        chk("underrun_count", 64'(ur_cnt - u), 1);

        f = frames;
        bus.src_sel = 0;
        bus.s0_left = 16'h1111; bus.s0_right = 16'h2222; bus.s0_valid = 1;
        step(1);
        bus.s0_valid = 0; bus.enable = 1;
        step(1);
        bus.s0_left = 16'h3333; bus.s0_right = 16'h4444; bus.s0_valid = 1;
        step(1);
        bus.s0_valid = 0;
        wait_p(8);
        bus.src_sel = 1;
        bus.s0_left = 16'h7777; bus.s0_right = 16'h7777; bus.s0_valid = 1;
        bus.s1_left = 16'h5555; bus.s1_right = 16'h6666; bus.s1_valid = 1;
        wait_frames(f + 2);
        bus.s0_valid = 0; bus.s1_valid = 0; bus.enable = 0;
        wait_idle();
        step(2);
        chk("switch_frames", 64'(frames - f), 3);
        chk("switch_active_src", bus.active_src, 1);

        bus.src_sel = 1;
        bus.s0_left = 16'h1234; bus.s0_right = 16'h5678; bus.s0_valid = 1;
        bus.s1_left = 16'h1234; bus.s1_right = 16'h5678; bus.s1_valid = 1;
        bus.enable = 1;
        step(1);
        s = s1x; u = ur_cnt;
        step(10 * FL);
        chk("b2b_s1_accepts", 64'(s1x - s), 10);
        chk("b2b_underruns", 64'(ur_cnt - u), 0);
        bus.enable = 0;
        wait_idle();
        bus.s0_valid = 0; bus.s1_valid = 0;
        step(2);

        f = frames;
        bus.enable = 1;
        wait_p(5);
        bus.enable = 0;
        wait_idle();
        step(2);
        chk("stop_frames", 64'(frames - f), 1);
        chk_idle("stop");

        bus.enable = 1;
        wait_p(20);
        reset = 1;
        step(1);
        chk_idle("midreset");
        chk("midreset_s0_ready", bus.s0_ready, 0);
        chk("midreset_s1_ready", bus.s1_ready, 0);
        chk("midreset_active_src", bus.active_src, 0);
        reset = 0; bus.enable = 0;
        step(2);
        chk_idle("post_reset");
        chk("scoreboard_empty", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
